// File: rtl/latency_data_memory.sv
// Single-port word memory with byte enables and a fixed, programmable access latency.
// Latency: an accepted request completes MEM_LATENCY edges later; ready/rdata/err are valid in the cycle after that edge.
// Backpressure: one outstanding access; requests arriving while busy=1 are dropped, not queued.
module latency_data_memory #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int DEPTH       = 1024,
    parameter int MEM_LATENCY = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    output logic                busy,
    output logic                err
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                accept;
    logic                done;

    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [BE_W-1:0]     be_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                ready_q;
    logic                err_q;

    logic                in_range;
    logic [IDX_W-1:0]    idx;

    // No reset on the array: contents are undefined until written.
    logic [DATA_W-1:0]   mem [0:DEPTH-1];

    // Extra top bit so DEPTH == 2**ADDR_W compares correctly.
    assign in_range = ({1'b0, addr_q} < (ADDR_W + 1)'(DEPTH));
    assign idx      = addr_q[IDX_W-1:0];

    // Next-state logic: accept in IDLE, count down in BUSY, complete when the counter is exhausted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    accept  = 1'b1;
                    state_d = S_BUSY;
                    cnt_d   = CNT_W'(MEM_LATENCY - 1);
                end
            end
            S_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter, captured request and completion outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= done;
            err_q   <= done && !in_range;
            if (accept) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
                be_q    <= be;
            end
            if (done && !we_q) begin
                rdata_q <= in_range ? mem[idx] : '0;
            end
        end
    end

    // Byte-masked array write on completion; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (done && we_q && in_range) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be_q[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign err   = err_q;
    assign busy  = (state_q == S_BUSY);

endmodule

// File: tb/tb_latency_data_memory.sv
// Bench for latency_data_memory: two instances (latency 4 and latency 1) share one stimulus stream.
// Each instance has a transaction-level model (pending access + due edge number + word array).
// Outputs are compared every cycle 1 time unit after the rising edge.
module tb_latency_data_memory;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic [10:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be    = '0;

    logic [31:0] rdata_a, rdata_b;
    logic        ready_a, ready_b, busy_a, busy_b, err_a, err_b;

    int n_cmp = 0;
    int n_bad = 0;

    latency_data_memory #(.DATA_W(32), .ADDR_W(11), .DEPTH(1024), .MEM_LATENCY(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .rdata(rdata_a), .ready(ready_a), .busy(busy_a), .err(err_a)
    );

    latency_data_memory #(.DATA_W(32), .ADDR_W(11), .DEPTH(1024), .MEM_LATENCY(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .rdata(rdata_b), .ready(ready_b), .busy(busy_b), .err(err_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    // ---------------- behavioural model ----------------
    logic [31:0] mdl_mem [2][0:1023];
    bit          pend [2];
    int          due [2];
    logic        p_we [2];
    logic [10:0] p_addr [2];
    logic [31:0] p_wdata [2];
    logic [3:0]  p_be [2];
    logic        exp_busy [2];
    logic        exp_ready [2];
    logic        exp_err [2];
    logic [31:0] exp_rdata [2];
    int          edge_no = 0;

    initial begin
        for (int i = 0; i < 2; i++) begin
            pend[i] = 0; due[i] = 0; exp_busy[i] = 0; exp_ready[i] = 0;
            exp_err[i] = 0; exp_rdata[i] = '0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 2; i++) begin
                    pend[i] = 0; exp_busy[i] = 0; exp_ready[i] = 0;
                    exp_err[i] = 0; exp_rdata[i] = '0;
                end
            end else begin
                edge_no++;
                for (int i = 0; i < 2; i++) begin
                    exp_ready[i] = 0;
                    exp_err[i]   = 0;
                    if (pend[i]) begin
                        if (edge_no == due[i]) begin
                            pend[i]      = 0;
                            exp_ready[i] = 1;
                            if (p_addr[i] >= 11'd1024) begin
                                exp_err[i] = 1;
                                if (!p_we[i]) exp_rdata[i] = '0;
                            end else if (p_we[i]) begin
                                for (int b = 0; b < 4; b++)
                                    if (p_be[i][b]) mdl_mem[i][p_addr[i][9:0]][8*b +: 8] = p_wdata[i][8*b +: 8];
                            end else begin
                                exp_rdata[i] = mdl_mem[i][p_addr[i][9:0]];
                            end
                        end
                    end else if (req) begin
                        pend[i]    = 1;
                        due[i]     = edge_no + lat_of(i);
                        p_we[i]    = we;
                        p_addr[i]  = addr;
                        p_wdata[i] = wdata;
                        p_be[i]    = be;
                    end
                    exp_busy[i] = pend[i];
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(posedge clk);
        #1;
        if (rst_n) begin
            chk("busy_a",  {31'd0, busy_a},  {31'd0, exp_busy[0]});
            chk("ready_a", {31'd0, ready_a}, {31'd0, exp_ready[0]});
            chk("err_a",   {31'd0, err_a},   {31'd0, exp_err[0]});
            chk("rdata_a", rdata_a, exp_rdata[0]);
            chk("busy_b",  {31'd0, busy_b},  {31'd0, exp_busy[1]});
            chk("ready_b", {31'd0, ready_b}, {31'd0, exp_ready[1]});
            chk("err_b",   {31'd0, err_b},   {31'd0, exp_err[1]});
            chk("rdata_b", rdata_b, exp_rdata[1]);
        end
    end

    int rdy_a = 0;
    int rdy_b = 0;
    initial forever begin
        @(negedge clk);
        if (ready_a) rdy_a++;
        if (ready_b) rdy_b++;
    end

    // One access timed on instance A; optionally keeps driving a junk write while A is busy.
    task automatic access(input logic w, input logic [10:0] a, input logic [31:0] d,
                          input logic [3:0] b, input bit junk,
                          output logic [31:0] rd, output logic e, output int lat, output int bcnt);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        @(posedge clk);
        @(negedge clk);
        if (junk) begin
            req = 1'b1; we = 1'b1; addr = 11'd6; wdata = 32'hFFFF_FFFF; be = 4'hF;
        end else begin
            req = 1'b0;
        end
        lat = 0; bcnt = 0; rd = '0; e = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (ready_a) begin
                lat = k; rd = rdata_a; e = err_a;
                break;
            end
            if (busy_a) bcnt++;
        end
        if (lat == 0) chk("access_timeout", 32'd0, 32'd1);
        @(negedge clk);
        req = 1'b0;
    endtask

    logic [31:0] rd;
    logic        e;
    int          lat, bcnt, c0;
    logic [10:0] ra;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  {31'd0, busy_a},  32'd0);
        chk("rst_ready", {31'd0, ready_a}, 32'd0);
        chk("rst_err",   {31'd0, err_a},   32'd0);
        chk("rst_rdata", rdata_a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Give every address the bench touches a known value of zero.
        for (int i = 0; i < 20; i++) begin
            ra = (i < 16) ? 11'(i) : 11'(1020 + i - 16);
            access(1'b1, ra, 32'd0, 4'hF, 0, rd, e, lat, bcnt);
        end

        // Full write, latency and busy window
        access(1'b1, 11'd5, 32'hDEAD_BEEF, 4'hF, 0, rd, e, lat, bcnt);
        chk("wr_latency", 32'(lat), 32'd4);
        chk("wr_busy_cycles", 32'(bcnt), 32'd3);
        chk("wr_err", {31'd0, e}, 32'd0);
        #1;
        chk("wr_busy_after", {31'd0, busy_a}, 32'd0);

        // Byte-enable merge and read-back
        access(1'b1, 11'd5, 32'h1122_3344, 4'b0101, 0, rd, e, lat, bcnt);
        access(1'b0, 11'd5, 32'd0, 4'h0, 0, rd, e, lat, bcnt);
        chk("be_rdata", rd, 32'hDE22_BE44);
        chk("rd_latency", 32'(lat), 32'd4);

        // Write completion leaves rdata; be=0 leaves the word
        access(1'b1, 11'd5, 32'h0BAD_0BAD, 4'h0, 0, rd, e, lat, bcnt);
        chk("be0_ready", 32'(lat), 32'd4);
        chk("wr_keeps_rdata", rd, 32'hDE22_BE44);
        access(1'b0, 11'd5, 32'd0, 4'h0, 0, rd, e, lat, bcnt);
        chk("be0_unchanged", rd, 32'hDE22_BE44);

        // Requests while busy are ignored
        c0 = rdy_a;
        access(1'b1, 11'd8, 32'h1234_5678, 4'hF, 1, rd, e, lat, bcnt);
        repeat (6) @(negedge clk);
        chk("busy_one_pulse", 32'(rdy_a - c0), 32'd1);
        access(1'b0, 11'd6, 32'd0, 4'h0, 0, rd, e, lat, bcnt);
        chk("busy_ignore_addr6", rd, 32'd0);

        // Out of range
        access(1'b0, 11'd1023, 32'd0, 4'h0, 0, rd, e, lat, bcnt);
        chk("last_in_range_err", {31'd0, e}, 32'd0);
        access(1'b0, 11'd1024, 32'd0, 4'h0, 0, rd, e, lat, bcnt);
        chk("oob_rd_latency", 32'(lat), 32'd4);
        chk("oob_rd_err", {31'd0, e}, 32'd1);
        chk("oob_rd_rdata", rd, 32'd0);
        access(1'b1, 11'd1024, 32'hDEAD_BEEF, 4'hF, 0, rd, e, lat, bcnt);
        chk("oob_wr_err", {31'd0, e}, 32'd1);
        access(1'b0, 11'd0, 32'd0, 4'h0, 0, rd, e, lat, bcnt);
        chk("oob_wr_no_alias", rd, 32'd0);

        // Reset during an access: make rdata nonzero first
        access(1'b0, 11'd5, 32'd0, 4'h0, 0, rd, e, lat, bcnt);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 11'd7; wdata = 32'hCAFE_F00D; be = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy",  {31'd0, busy_a},  32'd0);
        chk("rst_mid_ready", {31'd0, ready_a}, 32'd0);
        chk("rst_mid_rdata", rdata_a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        access(1'b0, 11'd7, 32'd0, 4'h0, 0, rd, e, lat, bcnt);
        chk("rst_abort_addr7", rd, 32'd0);

        // Randomized traffic checked by the model
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            req   = ($urandom_range(0, 1) == 1);
            we    = ($urandom_range(0, 1) == 1);
            addr  = ($urandom_range(0, 3) == 0) ? 11'(1020 + $urandom_range(0, 10))
                                                : 11'($urandom_range(0, 15));
            wdata = $urandom;
            be    = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        req = 1'b0;

        // Latency 1, request held high: acceptance on alternate edges
        repeat (8) @(posedge clk);
        #1;
        c0 = rdy_b;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            req = 1'b1; we = 1'b0; addr = 11'(k % 16);
        end
        @(negedge clk);
        req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("l1_pulses", 32'(rdy_b - c0), 32'd10);

        repeat (8) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
